// File: rtl/subtractors_array_seq_pkg.sv
// Shared types and default widths for the sequential subtractor array.
package subtractors_array_seq_pkg;

  localparam int unsigned DEF_N_CH = 10;
  localparam int unsigned DEF_XW   = 8;
  localparam int unsigned DEF_SW   = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Element index width; a single-element vector still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/subtractors_array_seq_sat_sub.sv
// Single log-domain subtractor: exp_sum - x with negative flag and optional clamp.
module subtractors_array_seq_sat_sub
  import subtractors_array_seq_pkg::*;
#(
  parameter int unsigned XW  = DEF_XW,
  parameter int unsigned SW  = DEF_SW,
  parameter bit          SAT = 1'b1
) (
  input  logic [SW-1:0] i_a,
  input  logic [XW-1:0] i_b,
  output logic [SW-1:0] o_diff_c,
  output logic          o_neg_c
);

  logic [SW:0] w_d;

  // Extra MSB carries the borrow, i.e. the sign of the true difference.
  assign w_d      = {1'b0, i_a} - (SW+1)'(i_b);
  assign o_neg_c  = w_d[SW];
  assign o_diff_c = (SAT && w_d[SW]) ? '0 : w_d[SW-1:0];

endmodule

// File: rtl/subtractors_array_seq.sv
// Captures one exp_sum and N_CH exponents, then streams exp_sum - x_i one per handshake.
module subtractors_array_seq
  import subtractors_array_seq_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned XW   = DEF_XW,
  parameter int unsigned SW   = DEF_SW,
  parameter bit          SAT  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_sum_valid,
  output logic                     o_sum_ready,
  input  logic [SW-1:0]            i_exp_sum,
  input  logic                     i_x_valid,
  output logic                     o_x_ready,
  input  logic [XW-1:0]            i_x_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [SW-1:0]            o_out_data,
  output logic                     o_out_neg,
  output logic [idx_w(N_CH)-1:0]   o_out_idx,
  output logic                     o_out_last,
  output logic                     o_busy
);

  localparam int unsigned   IW       = idx_w(N_CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  state_t        r_state, w_state;
  logic [IW-1:0] r_cnt, w_cnt;
  logic [SW-1:0] r_sum, w_sum;
  logic [XW-1:0] r_buf [N_CH];
  logic          r_sum_ready, w_sum_ready;
  logic          r_x_ready, w_x_ready;
  logic          r_out_valid, w_out_valid;
  logic [SW-1:0] r_out_data, w_out_data;
  logic          r_out_neg, w_out_neg;
  logic          r_out_last, w_out_last;
  logic          r_busy, w_busy;

  logic          w_sum_fire, w_x_fire, w_out_fire, w_load_res;
  logic [IW-1:0] w_rd_idx;
  logic [XW-1:0] w_rd_x;
  logic [SW-1:0] w_diff;
  logic          w_neg;

  assign w_sum_fire = r_sum_ready & i_sum_valid;
  assign w_x_fire   = r_x_ready & i_x_valid;
  assign w_out_fire = r_out_valid & i_out_ready;

  // Operand for the next registered result: element 0 when leaving LOAD, else idx+1.
  assign w_rd_idx = (r_state == ST_EMIT) ? IW'(r_cnt + IW'(1)) : '0;
  assign w_rd_x   = (N_CH == 1 && r_state == ST_LOAD) ? i_x_data : r_buf[w_rd_idx];

  subtractors_array_seq_sat_sub #(
    .XW  (XW),
    .SW  (SW),
    .SAT (SAT)
  ) u_sat_sub (
    .i_a      (r_sum),
    .i_b      (w_rd_x),
    .o_diff_c (w_diff),
    .o_neg_c  (w_neg)
  );

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_sum       = r_sum;
    w_sum_ready = r_sum_ready;
    w_x_ready   = r_x_ready;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_neg   = r_out_neg;
    w_out_last  = r_out_last;
    w_load_res  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_sum_fire) begin
          w_state     = ST_LOAD;
          w_cnt       = '0;
          w_sum       = i_exp_sum;
          w_sum_ready = 1'b0;
          w_x_ready   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_x_fire) begin
          if (r_cnt == LAST_IDX) begin
            w_state    = ST_EMIT;
            w_cnt      = '0;
            w_x_ready  = 1'b0;
            w_load_res = 1'b1;
          end else begin
            w_cnt = IW'(r_cnt + IW'(1));
          end
        end
      end
      ST_EMIT: begin
        if (w_out_fire) begin
          if (r_out_last) begin
            w_state     = ST_IDLE;
            w_cnt       = '0;
            w_out_valid = 1'b0;
            w_sum_ready = 1'b1;
          end else begin
            w_cnt      = IW'(r_cnt + IW'(1));
            w_load_res = 1'b1;
          end
        end
      end
      default: begin
        w_state     = ST_IDLE;
        w_cnt       = '0;
        w_sum_ready = 1'b1;
        w_x_ready   = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase

    if (w_load_res) begin
      w_out_valid = 1'b1;
      w_out_data  = w_diff;
      w_out_neg   = w_neg;
      w_out_last  = (w_cnt == LAST_IDX);
    end

    // Abort overrides every handshake seen in the same cycle.
    if (i_flush) begin
      w_state     = ST_IDLE;
      w_cnt       = '0;
      w_sum_ready = 1'b1;
      w_x_ready   = 1'b0;
      w_out_valid = 1'b0;
    end

    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_ready <= 1'b1;
      r_x_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_neg   <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_sum       <= w_sum;
      r_sum_ready <= w_sum_ready;
      r_x_ready   <= w_x_ready;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_neg   <= w_out_neg;
      r_out_last  <= w_out_last;
      r_busy      <= w_busy;
    end
  end

  // Element buffer is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (w_x_fire && !i_flush) begin
      r_buf[r_cnt] <= i_x_data;
    end
  end

  assign o_sum_ready = r_sum_ready;
  assign o_x_ready   = r_x_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_neg   = r_out_neg;
  assign o_out_idx   = r_cnt;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_subtractors_array_seq.sv
// Scoreboard bench: saturating and wrapping N_CH=10 instances plus an N_CH=1 instance.
module tb_subtractors_array_seq;

  localparam int unsigned N_CH = 10;
  localparam int unsigned XW   = 8;
  localparam int unsigned SW   = 9;

  typedef struct {
    int data;
    bit neg;
    int idx;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush, sum_valid, x_valid, out_ready;
  logic [SW-1:0] exp_sum;
  logic [XW-1:0] x_data;

  logic          a_sum_ready, a_x_ready, a_out_valid, a_out_neg, a_out_last, a_busy;
  logic [SW-1:0] a_out_data;
  logic [3:0]    a_out_idx;
  logic          b_sum_ready, b_x_ready, b_out_valid, b_out_neg, b_out_last, b_busy;
  logic [SW-1:0] b_out_data;
  logic [3:0]    b_out_idx;

  logic          c_sum_valid, c_x_valid, c_out_ready;
  logic [SW-1:0] c_exp_sum;
  logic [XW-1:0] c_x_data;
  logic          c_sum_ready, c_x_ready, c_out_valid, c_out_neg, c_out_last, c_busy;
  logic [SW-1:0] c_out_data;
  logic [0:0]    c_out_idx;

  int   n_vec = 0;
  int   n_err = 0;
  int   rmode = 0;
  int   gap_max = 0;
  int   xv [N_CH];
  exp_t qa [$];
  exp_t qb [$];

  always #5 clk = ~clk;

  subtractors_array_seq #(.N_CH(N_CH), .XW(XW), .SW(SW), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_sum_valid(sum_valid), .o_sum_ready(a_sum_ready), .i_exp_sum(exp_sum),
    .i_x_valid(x_valid), .o_x_ready(a_x_ready), .i_x_data(x_data),
    .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_data(a_out_data),
    .o_out_neg(a_out_neg), .o_out_idx(a_out_idx), .o_out_last(a_out_last), .o_busy(a_busy)
  );

  subtractors_array_seq #(.N_CH(N_CH), .XW(XW), .SW(SW), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_sum_valid(sum_valid), .o_sum_ready(b_sum_ready), .i_exp_sum(exp_sum),
    .i_x_valid(x_valid), .o_x_ready(b_x_ready), .i_x_data(x_data),
    .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_data(b_out_data),
    .o_out_neg(b_out_neg), .o_out_idx(b_out_idx), .o_out_last(b_out_last), .o_busy(b_busy)
  );

  subtractors_array_seq #(.N_CH(1), .XW(XW), .SW(SW), .SAT(1'b1)) dut_one (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_sum_valid(c_sum_valid), .o_sum_ready(c_sum_ready), .i_exp_sum(c_exp_sum),
    .i_x_valid(c_x_valid), .o_x_ready(c_x_ready), .i_x_data(c_x_data),
    .o_out_valid(c_out_valid), .i_out_ready(c_out_ready), .o_out_data(c_out_data),
    .o_out_neg(c_out_neg), .o_out_idx(c_out_idx), .o_out_last(c_out_last), .o_busy(c_busy)
  );

  // Reference: plain integer subtraction, clamped or wrapped modulo 2^SW.
  function automatic exp_t model(input int s, input int x, input bit sat, input int idx, input int n);
    exp_t e;
    e.neg  = (s < x);
    e.data = !e.neg ? (s - x) : (sat ? 0 : (s - x + (1 << SW)));
    e.idx  = idx;
    e.last = (idx == n - 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e, input logic [SW-1:0] d,
                         input logic ng, input logic [3:0] ix, input logic ls);
    chk({tag, "_data"}, 32'(d), 32'(e.data));
    chk({tag, "_neg"},  32'(ng), 32'(e.neg));
    chk({tag, "_idx"},  32'(ix), 32'(e.idx));
    chk({tag, "_last"}, 32'(ls), 32'(e.last));
  endtask

  task automatic monitor();
    logic [SW-1:0] ha_d, hb_d;
    logic [3:0]    ha_i, hb_i;
    bit            sa, sb;
    exp_t          e;
    sa = 0;
    sb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sa = 0;
        sb = 0;
      end else begin
        if (sa && a_out_valid) begin
          chk("sat_stall_data", 32'(a_out_data), 32'(ha_d));
          chk("sat_stall_idx", 32'(a_out_idx), 32'(ha_i));
        end
        if (sb && b_out_valid) begin
          chk("wrap_stall_data", 32'(b_out_data), 32'(hb_d));
          chk("wrap_stall_idx", 32'(b_out_idx), 32'(hb_i));
        end
        sa = a_out_valid && !out_ready;
        sb = b_out_valid && !out_ready;
        ha_d = a_out_data; ha_i = a_out_idx;
        hb_d = b_out_data; hb_i = b_out_idx;
        if (a_out_valid && out_ready) begin
          if (qa.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sat_extra_output: got idx %0d expected none", a_out_idx);
          end else begin
            e = qa.pop_front();
            chk_out("sat", e, a_out_data, a_out_neg, a_out_idx, a_out_last);
          end
        end
        if (b_out_valid && out_ready) begin
          if (qb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wrap_extra_output: got idx %0d expected none", b_out_idx);
          end else begin
            e = qb.pop_front();
            chk_out("wrap", e, b_out_data, b_out_neg, b_out_idx, b_out_last);
          end
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  // Drives one vector from xv; flush_at>0 aborts on that x handshake number.
  task automatic send_vec(input int s, input int flush_at);
    int t;
    sum_valid = 1'b1;
    exp_sum   = SW'(s);
    t = 0;
    @(negedge clk);
    while (!a_sum_ready && t < 200) begin @(negedge clk); t++; end
    chk("sum_ready_wait", 32'(a_sum_ready), 32'd1);
    @(posedge clk); #1;
    sum_valid = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      x_valid = 1'b1;
      x_data  = XW'(xv[i]);
      if (i == N_CH - 1 && flush_at <= 0) begin
        for (int k = 0; k < N_CH; k++) begin
          qa.push_back(model(s, xv[k], 1'b1, k, N_CH));
          qb.push_back(model(s, xv[k], 1'b0, k, N_CH));
        end
      end
      t = 0;
      @(negedge clk);
      while (!a_x_ready && t < 200) begin @(negedge clk); t++; end
      chk("x_ready_wait", 32'(a_x_ready), 32'd1);
      if (i + 1 == flush_at) flush = 1'b1;
      @(posedge clk); #1;
      x_valid = 1'b0;
      if (flush) begin
        flush = 1'b0;
        chk("flush_busy", 32'(a_busy), 32'd0);
        chk("flush_sum_ready", 32'(a_sum_ready), 32'd1);
        chk("flush_out_valid", 32'(a_out_valid), 32'd0);
        return;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 1000) begin @(posedge clk); t++; end
    chk("drain_left", 32'(qa.size() + qb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic one_elem(input int s, input int x);
    exp_t e;
    int   t;
    e = model(s, x, 1'b1, 0, 1);
    c_sum_valid = 1'b1; c_exp_sum = SW'(s);
    t = 0;
    @(negedge clk);
    while (!c_sum_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    c_sum_valid = 1'b0; c_x_valid = 1'b1; c_x_data = XW'(x);
    t = 0;
    @(negedge clk);
    while (!c_x_ready && t < 50) begin @(negedge clk); t++; end
    chk("one_x_ready", 32'(c_x_ready), 32'd1);
    @(posedge clk); #1;
    c_x_valid = 1'b0;
    @(negedge clk);
    chk("one_valid", 32'(c_out_valid), 32'd1);
    chk_out("one", e, c_out_data, c_out_neg, 4'(c_out_idx), c_out_last);
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    @(negedge clk);
    chk("one_done_valid", 32'(c_out_valid), 32'd0);
    chk("one_done_busy", 32'(c_busy), 32'd0);
  endtask

  initial begin
    int s;
    bit found;
    rst = 1'b1; flush = 1'b0; sum_valid = 1'b0; x_valid = 1'b0; out_ready = 1'b1;
    exp_sum = '0; x_data = '0;
    c_sum_valid = 1'b0; c_x_valid = 1'b0; c_out_ready = 1'b0; c_exp_sum = '0; c_x_data = '0;
    fork
      monitor();
      ready_driver();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_sum_ready", 32'(a_sum_ready), 32'd1);
    chk("rst_x_ready", 32'(a_x_ready), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_last", 32'(a_out_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector, both SAT settings checked together.
    xv = '{100, 75, 25, 37, 62, 87, 112, 125, 50, 45};
    send_vec(50, 0);
    drain();

    // Width edge: full-scale sum against 0 and 255.
    for (int i = 0; i < N_CH; i++) xv[i] = (i % 2 == 0) ? 0 : 255;
    send_vec(511, 0);
    drain();

    // Back-pressure toggling every cycle.
    rmode = 1;
    for (int i = 0; i < N_CH; i++) xv[i] = $urandom_range(0, 255);
    send_vec($urandom_range(0, 511), 0);
    drain();
    rmode = 0;

    // Flush mid-load, then a clean vector must not see stale elements.
    for (int i = 0; i < N_CH; i++) xv[i] = $urandom_range(0, 255);
    send_vec($urandom_range(0, 511), 4);
    for (int i = 0; i < N_CH; i++) xv[i] = 10;
    send_vec(20, 0);
    drain();

    // Randomised vectors with input gaps and random back-pressure.
    gap_max = 2;
    for (int v = 0; v < 20; v++) begin
      rmode = $urandom_range(0, 2);
      for (int i = 0; i < N_CH; i++) xv[i] = $urandom_range(0, 255);
      send_vec($urandom_range(0, 511), 0);
      drain();
    end
    gap_max = 0;
    rmode = 0;

    // Async reset while emitting idx 3.
    for (int i = 0; i < N_CH; i++) xv[i] = $urandom_range(0, 255);
    send_vec($urandom_range(0, 511), 0);
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(posedge clk); #2;
      if (a_out_valid && a_out_idx == 4'd3) found = 1;
    end
    chk("idx3_reached", 32'(found), 32'd1);
    rmode = 3; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_sum_ready", 32'(a_sum_ready), 32'd1);
    chk("mid_rst_busy", 32'(b_busy), 32'd0);
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rmode = 0;
    for (int i = 0; i < N_CH; i++) xv[i] = $urandom_range(0, 255);
    send_vec($urandom_range(0, 511), 0);
    drain();

    // Single-element build.
    one_elem(30, 200);
    one_elem(200, 30);
    s = $urandom_range(0, 511);
    one_elem(s, $urandom_range(0, 255));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
